// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing constants,
// also used by the transmitter.
package uart_pkg;

  localparam int DEFAULT_SAMPLE_RATE = 16;
  localparam int DEFAULT_DATA_BITS   = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable
// reset level so idle-high and idle-low lines both come out of reset quietly.
module synchronizer #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [1:0] stage_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_reg <= {2{RESET_VALUE}};
    end else begin
      stage_reg <= {stage_reg[0], din};
    end
  end

  assign dout = stage_reg[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver driven by a 16x oversample tick: start validation at
// mid-start, mid-bit data sampling, stop check, and a valid/ready output byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
  parameter int DATA_BITS   = DEFAULT_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLE_RATE);
  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE_RATE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_RATE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [IW-1:0]        idx_reg;
  logic [DATA_BITS-1:0] shreg_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 data_valid_reg;
  logic                 framing_error_reg;
  logic                 overrun_reg;
  logic                 busy_reg;

  logic                 stop_sample;
  logic                 load;
  logic                 overrun_hit;
  logic                 frame_bad;
  logic [DATA_BITS:0]   shift_wide;

  synchronizer #(.RESET_VALUE(1'b1)) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .din   (rx),
    .dout  (rx_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else if (tick) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (!rx_s) state_next = START;
      START: if (cnt_reg == CNT_HALF) state_next = rx_s ? IDLE : DATA;
      DATA:  if (cnt_reg == CNT_LAST && idx_reg == IDX_LAST) state_next = STOP;
      STOP:  if (cnt_reg == CNT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A consumer accepting in the stop-sample cycle frees the slot, so the new byte loads
  always_comb begin
    stop_sample = tick && (state_reg == STOP) && (cnt_reg == CNT_LAST);
    load        = stop_sample && rx_s && (!data_valid_reg || data_ready);
    overrun_hit = stop_sample && rx_s && data_valid_reg && !data_ready;
    frame_bad   = stop_sample && !rx_s;
    shift_wide  = {rx_s, shreg_reg};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg           <= '0;
      idx_reg           <= '0;
      shreg_reg         <= '0;
      data_reg          <= '0;
      data_valid_reg    <= 1'b0;
      framing_error_reg <= 1'b0;
      overrun_reg       <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      framing_error_reg <= frame_bad;
      overrun_reg       <= overrun_hit;
      if (tick) begin
        busy_reg <= (state_next != IDLE);
        unique case (state_reg)
          IDLE: cnt_reg <= '0;
          START: begin
            idx_reg <= '0;
            cnt_reg <= (cnt_reg == CNT_HALF) ? '0 : cnt_reg + CW'(1);
          end
          DATA: begin
            if (cnt_reg == CNT_LAST) begin
              cnt_reg   <= '0;
              idx_reg   <= idx_reg + IW'(1);
              shreg_reg <= shift_wide[DATA_BITS:1];
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          STOP: cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
          default: cnt_reg <= '0;
        endcase
      end
      if (load) begin
        data_reg       <= shreg_reg;
        data_valid_reg <= 1'b1;
      end else if (data_valid_reg && data_ready) begin
        data_valid_reg <= 1'b0;
      end
    end
  end

  assign data          = data_reg;
  assign data_valid    = data_valid_reg;
  assign framing_error = framing_error_reg;
  assign overrun       = overrun_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomised frames for uart_receiver, checked against a frame-level
// model of what the consumer should see (bytes, pulses, held data).
module tb_uart_receiver;

  localparam int SR      = 16;
  localparam int TDIV    = 4;
  localparam int BIT_CLK = SR * TDIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0;
  int ov_seen = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_fe = 0;
  int         m_ov = 0;

  uart_receiver #(.SAMPLE_RATE(SR), .DATA_BITS(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .rx            (rx),
    .data          (data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clock);
      tick = (ph == TDIV - 1);
      ph = (ph + 1) % TDIV;
    end
  end

  // Counts high cycles of each pulse and logs every byte the consumer is offered
  always @(negedge clock) begin
    if (framing_error) fe_seen++;
    if (overrun) ov_seen++;
    if (data_valid && (!prev_valid || data != prev_data)) got_q.push_back(data);
    prev_valid = data_valid;
    prev_data = data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(m_valid));
    chk({tag, ".data"}, 32'(data), 32'(m_data));
    chk({tag, ".framing_errors"}, 32'(fe_seen), 32'(m_fe));
    chk({tag, ".overruns"}, 32'(ov_seen), 32'(m_ov));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    $display("frame %s: data=%02h valid=%b fe=%0d ov=%0d", tag, data, data_valid, fe_seen, ov_seen);
  endtask

  // Frame-level outcome: what the consumer should see once the stop bit is judged
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic rdy);
    if (rdy) m_valid = 1'b0;
    if (!stop) begin
      m_fe++;
    end else if (m_valid) begin
      m_ov++;
    end else begin
      m_valid = 1'b1;
      m_data = b;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rdy);
    rx = 1'b0;
    if (rdy) begin
      data_ready = 1'b1;
      @(negedge clock);
      data_ready = 1'b0;
      repeat (BIT_CLK - 1) @(negedge clock);
    end else begin
      repeat (BIT_CLK) @(negedge clock);
    end
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clock);
    end
    rx = stop;
    repeat (BIT_CLK) @(negedge clock);
    rx = 1'b1;
    model_frame(b, stop, rdy);
  endtask

  task automatic accept_byte(input string tag);
    data_ready = 1'b1;
    @(negedge clock);
    data_ready = 1'b0;
    @(negedge clock);
    m_valid = 1'b0;
    chk({tag, ".valid_cleared"}, 32'(data_valid), 32'(m_valid));
  endtask

  initial begin : main
    logic [7:0] b;
    logic       stop;
    logic       rdy;
    int         gap;
    int         n;

    repeat (4) @(negedge clock);
    chk("reset.data", 32'(data), 32'h00);
    chk("reset.data_valid", 32'(data_valid), 32'd0);
    chk("reset.framing_error", 32'(framing_error), 32'd0);
    chk("reset.overrun", 32'(overrun), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clock);

    send_frame(8'hA5, 1'b1, 1'b0);
    check_state("a5_hold");
    repeat (100) @(negedge clock);
    chk("a5_still_valid", 32'(data_valid), 32'd1);
    accept_byte("a5");

    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1);
    check_state("3c_c3");
    accept_byte("c3");

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check_state("11_22_overrun");
    accept_byte("11");

    send_frame(8'h55, 1'b0, 1'b0);
    repeat (3 * BIT_CLK) @(negedge clock);
    check_state("55_bad_stop");
    send_frame(8'h0F, 1'b1, 1'b0);
    check_state("0f_after_bad");

    rx = 1'b0;
    repeat (3 * TDIV) @(negedge clock);
    rx = 1'b1;
    chk("glitch.busy_high", 32'(busy), 32'd1);
    repeat (BIT_CLK) @(negedge clock);
    check_state("glitch");

    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clock);
    rx = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clock);
    chk("midframe.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_valid = 1'b0;
    m_data = 8'h00;
    chk("midreset.data", 32'(data), 32'h00);
    chk("midreset.data_valid", 32'(data_valid), 32'd0);
    chk("midreset.busy", 32'(busy), 32'd0);
    chk("midreset.framing_error", 32'(framing_error), 32'd0);
    chk("midreset.overrun", 32'(overrun), 32'd0);
    repeat (2 * BIT_CLK) @(negedge clock);
    check_state("after_reset_idle");
    send_frame(8'h81, 1'b1, 1'b0);
    check_state("81_after_reset");

    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      rdy = 1'($urandom_range(0, 1));
      send_frame(b, stop, rdy);
      gap = stop ? $urandom_range(0, 30) : 3 * BIT_CLK;
      repeat (gap) @(negedge clock);
      check_state($sformatf("rand%0d_%02h_s%0b_r%0b", k, b, stop, rdy));
    end

    chk("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("byte_order[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
